spi_cmd_sequencer: RTL and testbench

- Parses the framed byte stream from the SPI byte receiver into two command types.
- Sprite upload: sprite pixels are written into sprite memory through its write port.
- Draw: a draw record is pushed into the draw queue that the renderer drains via dequeue/is_empty.
- Sits between the SPI byte receiver and the sprite memory / draw queue inside main.

---
 rtl/spi_cmd_sequencer_pkg.sv | 55 +++++
 rtl/spi_cmd_sequencer_if.sv | 37 +++
 rtl/spi_cmd_sequencer_spr_nibble_writer.sv | 60 ++++++
 rtl/spi_cmd_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared types and constants for the SPI command sequencer: parser states,
// command bytes, draw record layout and sprite memory geometry.
package spi_cmd_pkg;

  localparam int NUM_SPRITES      = 16;
  localparam int SPRITE_PIXELS    = 1024;
  localparam int SPRITE_ADDR_W    = 14;
  localparam int PIX_IDX_W        = $clog2(SPRITE_PIXELS);
  localparam int SPR_ID_W         = SPRITE_ADDR_W - PIX_IDX_W;
  localparam int BYTES_PER_SPRITE = SPRITE_PIXELS / 2;
  localparam int BYTE_CNT_W       = $clog2(BYTES_PER_SPRITE);

  localparam logic [7:0] CMD_UPLOAD = 8'h01;
  localparam logic [7:0] CMD_DRAW   = 8'h02;
  localparam logic [7:0] END_BYTE   = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_UPL_ID,
    ST_UPL_DATA,
    ST_UPL_END,
    ST_DRW_ID,
    ST_DRW_XH,
    ST_DRW_XL,
    ST_DRW_YH,
    ST_DRW_YL,
    ST_DRW_SCALE,
    ST_DRW_END,
    ST_DISCARD
  } state_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } draw_rec_t;

  // Unknown command bytes fall through to DISCARD; callers flag err_cmd on that.
  function automatic state_t cmd_next_state(input logic [7:0] cmd);
    state_t st;
    case (cmd)
      CMD_UPLOAD: st = ST_UPL_ID;
      CMD_DRAW:   st = ST_DRW_ID;
      default:    st = ST_DISCARD;
    endcase
    return st;
  endfunction

  function automatic logic sprite_id_ok(input logic [7:0] id);
    return id < 8'(NUM_SPRITES);
  endfunction

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Byte-stream input, sprite-memory write port and draw-queue push port of
// the command sequencer, grouped into one bundle.
interface spi_cmd_sequencer_if;

  logic                                  spi_cs_n;
  logic                                  byte_valid;
  logic [7:0]                            byte_data;
  logic                                  spr_w_en;
  logic [spi_cmd_pkg::SPRITE_ADDR_W-1:0] spr_w_addr;
  logic [3:0]                            spr_w_data;
  logic                                  q_push;
  logic                                  q_full;
  logic [7:0]                            q_id;
  logic [15:0]                           q_x;
  logic [15:0]                           q_y;
  logic [7:0]                            q_scale;
  logic                                  busy;
  logic                                  upload_done;
  logic                                  err_cmd;
  logic                                  err_frame;
  logic                                  err_drop;

  modport slave (
    input  spi_cs_n, byte_valid, byte_data, q_full,
    output spr_w_en, spr_w_addr, spr_w_data,
    output q_push, q_id, q_x, q_y, q_scale,
    output busy, upload_done, err_cmd, err_frame, err_drop
  );

  modport master (
    output spi_cs_n, byte_valid, byte_data, q_full,
    input  spr_w_en, spr_w_addr, spr_w_data,
    input  q_push, q_id, q_x, q_y, q_scale,
    input  busy, upload_done, err_cmd, err_frame, err_drop
  );

endinterface

// File: rtl/spi_cmd_sequencer_spr_nibble_writer.sv
// Turns each accepted sprite byte into two consecutive nibble writes
// (high nibble first) and walks the pixel address of the current sprite.
module spr_nibble_writer
  import spi_cmd_pkg::*;
(
  input  logic                     sys_clock,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic [SPR_ID_W-1:0]      i_id,
  input  logic                     i_load,
  input  logic [7:0]               i_byte,
  output logic                     o_w_en,
  output logic [SPRITE_ADDR_W-1:0] o_w_addr,
  output logic [3:0]               o_w_data
);

  logic [SPRITE_ADDR_W-1:0] r_addr;
  logic                     r_lo_pend;
  logic [3:0]               r_lo_nib;
  logic                     r_w_en;
  logic [SPRITE_ADDR_W-1:0] r_w_addr;
  logic [3:0]               r_w_data;

  // Byte strobes are at least two cycles apart, so the low nibble always
  // drains before the next byte can load.
  always_ff @(posedge sys_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_lo_pend <= 1'b0;
      r_lo_nib  <= '0;
      r_w_en    <= 1'b0;
      r_w_addr  <= '0;
      r_w_data  <= '0;
    end else begin
      r_w_en <= 1'b0;
      if (i_start) begin
        r_addr <= {i_id, {PIX_IDX_W{1'b0}}};
      end
      if (i_load) begin
        r_w_en    <= 1'b1;
        r_w_addr  <= r_addr;
        r_w_data  <= i_byte[7:4];
        r_lo_nib  <= i_byte[3:0];
        r_lo_pend <= 1'b1;
        r_addr    <= r_addr + SPRITE_ADDR_W'(1);
      end else if (r_lo_pend) begin
        r_w_en    <= 1'b1;
        r_w_addr  <= r_addr;
        r_w_data  <= r_lo_nib;
        r_lo_pend <= 1'b0;
        r_addr    <= r_addr + SPRITE_ADDR_W'(1);
      end
    end
  end

  assign o_w_en   = r_w_en;
  assign o_w_addr = r_w_addr;
  assign o_w_data = r_w_data;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Parses framed SPI bytes into sprite uploads (nibble writes to sprite
// memory) and draw records (pushes into the renderer's draw queue).
//
// state        | meaning
// IDLE         | no frame active
// CMD          | frame open, waiting for command byte
// UPL_ID       | waiting for sprite id
// UPL_DATA     | receiving 512 pixel bytes
// UPL_END      | waiting for upload end byte
// DRW_ID..END  | collecting draw fields, then end byte
// DISCARD      | command finished or rejected, ignore until cs_n rises
module spi_cmd_sequencer
  import spi_cmd_pkg::*;
(
  input logic              sys_clock,
  input logic              rst_n,
  spi_cmd_sequencer_if.slave bus
);

  state_t                r_state;
  state_t                w_state_nxt;
  state_t                w_cmd_state;
  logic                  r_cs_n_d;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  draw_rec_t             r_hold;
  draw_rec_t             r_q;
  logic                  r_push;
  logic                  r_upload_done;
  logic                  r_err_cmd;
  logic                  r_err_frame;
  logic                  r_err_drop;

  logic w_cs_fall;
  logic w_cs_rise;
  logic w_byte;
  logic w_push;
  logic w_upload_done;
  logic w_err_cmd;
  logic w_err_frame;
  logic w_err_drop;
  logic w_nib_start;
  logic w_nib_load;

  assign w_cs_fall   = r_cs_n_d & ~bus.spi_cs_n;
  assign w_cs_rise   = ~r_cs_n_d & bus.spi_cs_n;
  // A strobe arriving as cs_n rises is outside the frame and is dropped.
  assign w_byte      = bus.byte_valid & ~bus.spi_cs_n;
  assign w_cmd_state = cmd_next_state(bus.byte_data);

  always_ff @(posedge sys_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cs_n_d <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cs_n_d <= bus.spi_cs_n;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_push        = 1'b0;
    w_upload_done = 1'b0;
    w_err_cmd     = 1'b0;
    w_err_frame   = 1'b0;
    w_err_drop    = 1'b0;
    w_nib_start   = 1'b0;
    w_nib_load    = 1'b0;
    if (w_cs_rise) begin
      w_state_nxt = ST_IDLE;
      w_err_frame = !(r_state inside {ST_IDLE, ST_CMD, ST_DISCARD});
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            if (w_byte) begin
              w_state_nxt = w_cmd_state;
              w_err_cmd   = (w_cmd_state == ST_DISCARD);
            end else begin
              w_state_nxt = ST_CMD;
            end
          end
        end
        ST_CMD: begin
          if (w_byte) begin
            w_state_nxt = w_cmd_state;
            w_err_cmd   = (w_cmd_state == ST_DISCARD);
          end
        end
        ST_UPL_ID: begin
          if (w_byte) begin
            if (sprite_id_ok(bus.byte_data)) begin
              w_state_nxt = ST_UPL_DATA;
              w_nib_start = 1'b1;
            end else begin
              w_state_nxt = ST_DISCARD;
              w_err_cmd   = 1'b1;
            end
          end
        end
        ST_UPL_DATA: begin
          if (w_byte) begin
            w_nib_load = 1'b1;
            if (r_byte_cnt == '0) w_state_nxt = ST_UPL_END;
          end
        end
        ST_UPL_END: begin
          if (w_byte) begin
            w_state_nxt   = ST_DISCARD;
            w_upload_done = (bus.byte_data == END_BYTE);
            w_err_frame   = (bus.byte_data != END_BYTE);
          end
        end
        ST_DRW_ID:    if (w_byte) w_state_nxt = ST_DRW_XH;
        ST_DRW_XH:    if (w_byte) w_state_nxt = ST_DRW_XL;
        ST_DRW_XL:    if (w_byte) w_state_nxt = ST_DRW_YH;
        ST_DRW_YH:    if (w_byte) w_state_nxt = ST_DRW_YL;
        ST_DRW_YL:    if (w_byte) w_state_nxt = ST_DRW_SCALE;
        ST_DRW_SCALE: if (w_byte) w_state_nxt = ST_DRW_END;
        ST_DRW_END: begin
          if (w_byte) begin
            w_state_nxt = ST_DISCARD;
            if (bus.byte_data != END_BYTE) w_err_frame = 1'b1;
            else if (bus.q_full)           w_err_drop  = 1'b1;
            else                           w_push      = 1'b1;
          end
        end
        ST_DISCARD: w_state_nxt = ST_DISCARD;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Down-counter over the upload payload; terminal count marks the last byte.
  always_ff @(posedge sys_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
    end else if (w_nib_start) begin
      r_byte_cnt <= BYTE_CNT_W'(BYTES_PER_SPRITE - 1);
    end else if (w_nib_load) begin
      r_byte_cnt <= r_byte_cnt - BYTE_CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_byte) begin
      case (r_state)
        ST_DRW_ID:    r_hold.id         <= bus.byte_data;
        ST_DRW_XH:    r_hold.x[15:8]    <= bus.byte_data;
        ST_DRW_XL:    r_hold.x[7:0]     <= bus.byte_data;
        ST_DRW_YH:    r_hold.y[15:8]    <= bus.byte_data;
        ST_DRW_YL:    r_hold.y[7:0]     <= bus.byte_data;
        ST_DRW_SCALE: r_hold.scale      <= bus.byte_data;
        default:      r_hold            <= r_hold;
      endcase
    end
  end

  always_ff @(posedge sys_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_q           <= '0;
      r_push        <= 1'b0;
      r_upload_done <= 1'b0;
      r_err_cmd     <= 1'b0;
      r_err_frame   <= 1'b0;
      r_err_drop    <= 1'b0;
    end else begin
      r_push        <= w_push;
      r_upload_done <= w_upload_done;
      r_err_cmd     <= w_err_cmd;
      r_err_frame   <= w_err_frame;
      r_err_drop    <= w_err_drop;
      if (w_push) r_q <= r_hold;
    end
  end

  spr_nibble_writer u_nib_wr (
    .sys_clock (sys_clock),
    .rst_n     (rst_n),
    .i_start   (w_nib_start),
    .i_id      (bus.byte_data[SPR_ID_W-1:0]),
    .i_load    (w_nib_load),
    .i_byte    (bus.byte_data),
    .o_w_en    (bus.spr_w_en),
    .o_w_addr  (bus.spr_w_addr),
    .o_w_data  (bus.spr_w_data)
  );

  assign bus.q_push      = r_push;
  assign bus.q_id        = r_q.id;
  assign bus.q_x         = r_q.x;
  assign bus.q_y         = r_q.y;
  assign bus.q_scale     = r_q.scale;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.upload_done = r_upload_done;
  assign bus.err_cmd     = r_err_cmd;
  assign bus.err_frame   = r_err_frame;
  assign bus.err_drop    = r_err_drop;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: a frame-level reference model fills
// expectation queues, a monitor pops them as the DUT produces writes/pushes/pulses.
module tb_spi_cmd_sequencer;

  typedef logic [7:0] bq_t[$];

  localparam logic [3:0] EV_DONE  = 4'b1000;
  localparam logic [3:0] EV_CMD   = 4'b0100;
  localparam logic [3:0] EV_FRAME = 4'b0010;
  localparam logic [3:0] EV_DROP  = 4'b0001;

  logic sys_clock = 1'b0;
  logic rst_n     = 1'b0;
  always #5 sys_clock = ~sys_clock;

  spi_cmd_sequencer_if bus();

  spi_cmd_sequencer dut (
    .sys_clock (sys_clock),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;
  int n_uploads = 0;

  logic [17:0] exp_wr[$];
  logic [47:0] exp_push[$];
  logic [3:0]  exp_evt[$];
  logic [47:0] last_rec = '0;
  bit          mon_en = 1'b0;

  logic [17:0] m_wr;
  logic [47:0] m_push;
  logic [3:0]  m_evt;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  // Monitor: compares every DUT output event against the head of its queue.
  always @(negedge sys_clock) begin
    if (mon_en && rst_n) begin
      if (bus.spr_w_en) begin
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected addr=%0d data=%0h exp=none", bus.spr_w_addr, bus.spr_w_data);
        end else begin
          m_wr = exp_wr.pop_front();
          chk("wr_addr_data", {bus.spr_w_addr, bus.spr_w_data}, m_wr);
        end
      end
      if (bus.q_push) begin
        if (exp_push.size() == 0) begin
          checks++; failures++;
          $display("FAIL push_unexpected id=%0h exp=none", bus.q_id);
        end else begin
          m_push = exp_push.pop_front();
          chk("push_rec", {bus.q_id, bus.q_x, bus.q_y, bus.q_scale}, m_push);
        end
      end
      if ({bus.upload_done, bus.err_cmd, bus.err_frame, bus.err_drop} != 4'b0) begin
        if (exp_evt.size() == 0) begin
          checks++; failures++;
          $display("FAIL evt_unexpected got=%b exp=none",
                   {bus.upload_done, bus.err_cmd, bus.err_frame, bus.err_drop});
        end else begin
          m_evt = exp_evt.pop_front();
          chk("evt", {bus.upload_done, bus.err_cmd, bus.err_frame, bus.err_drop}, m_evt);
        end
      end
    end
  end

  // Frame-level reference: what a complete cs-low..cs-high frame must produce.
  task automatic model_frame(input bq_t fb, input bit full);
    int n;
    int nd;
    int base;
    logic [7:0] b;
    n = fb.size();
    if (n == 0) return;
    if (fb[0] == 8'h01) begin
      if (n < 2) exp_evt.push_back(EV_FRAME);
      else if (fb[1] >= 8'd16) exp_evt.push_back(EV_CMD);
      else begin
        nd = (n - 2 > 512) ? 512 : n - 2;
        for (int i = 0; i < nd; i++) begin
          b = fb[2 + i];
          base = int'(fb[1]) * 1024 + 2 * i;
          exp_wr.push_back({14'(base), b[7:4]});
          exp_wr.push_back({14'(base + 1), b[3:0]});
        end
        if (n < 515) exp_evt.push_back(EV_FRAME);
        else if (fb[514] == 8'h00) exp_evt.push_back(EV_DONE);
        else exp_evt.push_back(EV_FRAME);
      end
    end else if (fb[0] == 8'h02) begin
      if (n < 8 || fb[7] != 8'h00) exp_evt.push_back(EV_FRAME);
      else if (full) exp_evt.push_back(EV_DROP);
      else begin
        last_rec = {fb[1], fb[2], fb[3], fb[4], fb[5], fb[6]};
        exp_push.push_back(last_rec);
      end
    end else begin
      exp_evt.push_back(EV_CMD);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(posedge sys_clock); #1;
    bus.byte_valid = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge sys_clock);
    #1;
  endtask

  task automatic end_frame_check(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (exp_wr.size() == 0 && exp_push.size() == 0 && exp_evt.size() == 0) break;
      @(posedge sys_clock); #1;
    end
    repeat (3) @(posedge sys_clock);
    #1;
    chk({tag, "_wr_left"},   exp_wr.size(),   0);
    chk({tag, "_push_left"}, exp_push.size(), 0);
    chk({tag, "_evt_left"},  exp_evt.size(),  0);
    chk({tag, "_busy"},      bus.busy,        0);
    chk({tag, "_q_rec"},     {bus.q_id, bus.q_x, bus.q_y, bus.q_scale}, last_rec);
  endtask

  task automatic run_frame(input string tag, input bq_t fb, input bit full, input bit same_cycle);
    int start;
    model_frame(fb, full);
    bus.q_full = full;
    @(posedge sys_clock); #1;
    bus.spi_cs_n = 1'b0;
    if (same_cycle && fb.size() > 0) begin
      send_byte(fb[0]);
      start = 1;
    end else begin
      @(posedge sys_clock); #1;
      start = 0;
    end
    for (int i = start; i < fb.size(); i++) send_byte(fb[i]);
    repeat (2) @(posedge sys_clock);
    #1;
    bus.spi_cs_n = 1'b1;
    end_frame_check(tag);
    bus.q_full = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"}, {bus.spr_w_en, bus.spr_w_addr, bus.spr_w_data, bus.q_push,
                         bus.q_id, bus.q_x, bus.q_y, bus.q_scale, bus.upload_done,
                         bus.err_cmd, bus.err_frame, bus.err_drop}, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_wen"},  bus.spr_w_en, 0);
  endtask

  function automatic bq_t upload_frame(input logic [7:0] id, input logic [7:0] endb, input bit incr);
    bq_t fb;
    fb.push_back(8'h01);
    fb.push_back(id);
    for (int i = 0; i < 512; i++) fb.push_back(incr ? 8'(i % 256) : 8'($urandom_range(0, 255)));
    fb.push_back(endb);
    return fb;
  endfunction

  initial begin
    bq_t fb;
    int kind;
    int len;
    bus.spi_cs_n   = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.q_full     = 1'b0;
    repeat (3) @(posedge sys_clock);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge sys_clock);
    #1;

    run_frame("upload_id2", upload_frame(8'h02, 8'h00, 1'b1), 1'b0, 1'b0);

    fb = {8'h02, 8'h02, 8'h00, 8'h08, 8'h12, 8'h1A, 8'h02, 8'h00};
    run_frame("draw1", fb, 1'b0, 1'b0);
    run_frame("draw2", fb, 1'b0, 1'b1);
    chk("draw_q_x", bus.q_x, 16'h0008);
    chk("draw_q_y", bus.q_y, 16'h121A);

    fb = {8'h02, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h07, 8'h00};
    run_frame("draw_full", fb, 1'b1, 1'b0);
    chk("draw_full_q_id", bus.q_id, 8'h02);

    fb = {8'h02, 8'h09, 8'h00, 8'h08};
    run_frame("abort_xl", fb, 1'b0, 1'b0);

    fb = {8'h7F, 8'h01, 8'h02, 8'h00};
    run_frame("unknown_cmd", fb, 1'b0, 1'b1);

    fb = {8'h01, 8'h20, 8'h12, 8'h34, 8'h00};
    run_frame("bad_id", fb, 1'b0, 1'b0);

    run_frame("upload_badend", upload_frame(8'h0F, 8'h55, 1'b0), 1'b0, 1'b0);

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 9);
      if (kind >= 6 && kind <= 7 && n_uploads < 3) begin
        n_uploads++;
        fb = upload_frame(8'($urandom_range(0, 19)),
                          ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 1'b0);
        if ($urandom_range(0, 2) == 0) begin
          len = $urandom_range(1, 514);
          while (fb.size() > len) void'(fb.pop_back());
        end
      end else if (kind >= 8) begin
        fb = {};
        fb.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(3, 255)));
        for (int j = 0; j < $urandom_range(0, 4); j++) fb.push_back(8'($urandom_range(0, 255)));
      end else begin
        fb = {8'h02};
        for (int j = 0; j < 6; j++) fb.push_back(8'($urandom_range(0, 255)));
        fb.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
        if ($urandom_range(0, 4) == 0) begin
          len = $urandom_range(1, 7);
          while (fb.size() > len) void'(fb.pop_back());
        end else if ($urandom_range(0, 3) == 0) begin
          fb.push_back(8'($urandom_range(0, 255)));
        end
      end
      run_frame("rand", fb, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an upload, right as a nibble pair is in flight.
    mon_en = 1'b0;
    @(posedge sys_clock); #1;
    bus.spi_cs_n = 1'b0;
    @(posedge sys_clock); #1;
    send_byte(8'h01);
    send_byte(8'h05);
    for (int j = 0; j < 6; j++) send_byte(8'($urandom_range(0, 255)));
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hA5;
    @(posedge sys_clock); #1;
    bus.byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_wr.delete();
    exp_push.delete();
    exp_evt.delete();
    last_rec = '0;
    bus.spi_cs_n = 1'b1;
    repeat (3) @(posedge sys_clock);
    #1;
    check_all_zero("midreset_hold");
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge sys_clock);
    #1;
    fb = {8'h02, 8'h0C, 8'hBE, 8'hEF, 8'h00, 8'h40, 8'h03, 8'h00};
    run_frame("after_reset", fb, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    failures++;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
